// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg: shared types for the AXI4-Stream frame FIFO.
// Beat widths here set the default tdata/tkeep/tuser widths of the FIFO.
package axis_fifo_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
  localparam int AXIS_USER_W = 1;

  typedef enum logic {
    STORE = 1'b0,
    DROP  = 1'b1
  } in_state_e;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
    logic [AXIS_USER_W-1:0] user;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: one write port, one registered read port.
// The read register holds its value while i_re is low.
module axis_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/axis_frame_fifo_occ.sv
// axis_frame_fifo_occ: store-and-forward AXI4-Stream frame FIFO with status.
// AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN: discard frames ending with tuser[0]=1.
module axis_frame_fifo_occ
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_W,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = AXIS_USER_W,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic [ADDR_WIDTH:0]   cfg_almost_full_thresh,
  input  logic [ADDR_WIDTH:0]   cfg_almost_empty_thresh,
  output logic [ADDR_WIDTH:0]   status_occupancy,
  output logic [ADDR_WIDTH:0]   status_frame_count,
  output logic                  status_almost_full,
  output logic                  status_almost_empty,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] P_DEPTH = PW'(DEPTH);

  in_state_e r_state, w_state_nxt;
  logic [PW-1:0] r_wr_ptr_cur, r_wr_ptr, r_rd_ptr;
  logic [PW-1:0] r_frame_cnt;
  logic r_out_valid, r_in_frame, r_flushed;
  logic r_good, r_ovf, r_bad;

  logic w_accept, w_full_cur, w_oversize, w_bad;
  logic w_we, w_commit, w_rewind, w_ovf, w_bad_evt;
  logic w_re, w_out_last, w_flush_drop;
  beat_t w_wbeat, w_rbeat;

  assign s_axis_tready = rst_n;
  assign w_accept   = s_axis_tvalid & s_axis_tready;
  assign w_full_cur = (r_wr_ptr_cur - r_rd_ptr) == P_DEPTH;
  assign w_oversize = (r_wr_ptr_cur - r_wr_ptr) == P_DEPTH;

`ifdef AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN
  assign w_bad = s_axis_tuser[0];
`else
  assign w_bad = 1'b0;
`endif

  // A flush mid-frame keeps discarding until that frame's tlast.
  assign w_flush_drop = w_accept ? ~s_axis_tlast : r_in_frame;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= STORE;
      r_in_frame <= 1'b0;
      r_flushed  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_in_frame <= ~s_axis_tlast;
      if (flush)
        r_flushed <= w_flush_drop;
      else if (r_state == DROP && w_accept && s_axis_tlast)
        r_flushed <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      STORE:
        if (w_accept && !s_axis_tlast &&
            (w_full_cur || w_oversize))
          w_state_nxt = DROP;
      DROP:
        if (w_accept && s_axis_tlast)
          w_state_nxt = STORE;
      default: w_state_nxt = STORE;
    endcase
    if (flush) w_state_nxt = w_flush_drop ? DROP : STORE;
  end

  always_comb begin
    w_we      = 1'b0;
    w_commit  = 1'b0;
    w_rewind  = 1'b0;
    w_ovf     = 1'b0;
    w_bad_evt = 1'b0;
    unique case (r_state)
      STORE:
        if (w_accept) begin
          if (w_full_cur || w_oversize) begin
            w_rewind = s_axis_tlast;
            w_ovf    = s_axis_tlast;
          end else begin
            w_we = 1'b1;
            if (s_axis_tlast && w_bad) begin
              w_rewind  = 1'b1;
              w_bad_evt = 1'b1;
            end else begin
              w_commit = s_axis_tlast;
            end
          end
        end
      DROP:
        if (w_accept && s_axis_tlast) begin
          w_rewind = 1'b1;
          w_ovf    = ~r_flushed;
        end
      default: ;
    endcase
  end

  assign w_re = (r_rd_ptr != r_wr_ptr) &&
                (!r_out_valid || m_axis_tready);
  assign w_out_last = r_out_valid & m_axis_tready & w_rbeat.last;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr_cur <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_frame_cnt  <= '0;
      r_out_valid  <= 1'b0;
      r_good       <= 1'b0;
      r_ovf        <= 1'b0;
      r_bad        <= 1'b0;
    end else begin
      if (w_rewind)  r_wr_ptr_cur <= r_wr_ptr;
      else if (w_we) r_wr_ptr_cur <= r_wr_ptr_cur + 1'b1;
      if (w_commit) r_wr_ptr <= r_wr_ptr_cur + 1'b1;
      if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_out_valid <= w_re | (r_out_valid & ~m_axis_tready);
      if (w_commit && !w_out_last)
        r_frame_cnt <= r_frame_cnt + 1'b1;
      else if (!w_commit && w_out_last)
        r_frame_cnt <= r_frame_cnt - 1'b1;
      r_good <= w_commit;
      r_ovf  <= w_ovf;
      r_bad  <= w_bad_evt;
    end
  end

  assign w_wbeat = '{data: s_axis_tdata, keep: s_axis_tkeep,
                     last: s_axis_tlast, user: s_axis_tuser};

  axis_fifo_ram #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH),
    .AW    (PW - 1)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr_cur[PW-2:0]),
    .i_wdata (w_wbeat),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr[PW-2:0]),
    .o_rdata (w_rbeat)
  );

  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tdata  = w_rbeat.data;
  assign m_axis_tkeep  = w_rbeat.keep;
  assign m_axis_tlast  = w_rbeat.last;
  assign m_axis_tuser  = w_rbeat.user;

  assign status_occupancy    = r_wr_ptr - r_rd_ptr;
  assign status_frame_count  = r_frame_cnt;
  assign status_almost_full  = status_occupancy >= cfg_almost_full_thresh;
  assign status_almost_empty = status_occupancy <= cfg_almost_empty_thresh;
  assign status_good_frame   = r_good;
  assign status_overflow     = r_ovf;
`ifdef AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN
  assign status_bad_frame    = r_bad;
`else
  assign status_bad_frame    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_fifo_occ.sv
// tb_axis_frame_fifo_occ: directed frames, queue scoreboard on m_axis.
// Expected tuser handling follows AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN.
module tb_axis_frame_fifo_occ;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 1;
  localparam int DEPTH = 16;
  localparam int AW = 4;
`ifdef AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN
  localparam bit DROP_BAD = 1'b1;
`else
  localparam bit DROP_BAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tlast = 1'b0;
  logic s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic m_axis_tvalid, m_axis_tlast;
  logic m_axis_tready = 1'b1;
  logic [AW:0] cfg_af = 5'd12;
  logic [AW:0] cfg_ae = 5'd2;
  logic [AW:0] occ, fcnt;
  logic af, ae, ovf, badf, goodf;

  axis_frame_fifo_occ #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .USER_WIDTH (UW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .flush                   (flush),
    .s_axis_tdata            (s_axis_tdata),
    .s_axis_tkeep            (s_axis_tkeep),
    .s_axis_tuser            (s_axis_tuser),
    .s_axis_tvalid           (s_axis_tvalid),
    .s_axis_tlast            (s_axis_tlast),
    .s_axis_tready           (s_axis_tready),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tkeep            (m_axis_tkeep),
    .m_axis_tuser            (m_axis_tuser),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tlast            (m_axis_tlast),
    .m_axis_tready           (m_axis_tready),
    .cfg_almost_full_thresh  (cfg_af),
    .cfg_almost_empty_thresh (cfg_ae),
    .status_occupancy        (occ),
    .status_frame_count      (fcnt),
    .status_almost_full      (af),
    .status_almost_empty     (ae),
    .status_overflow         (ovf),
    .status_bad_frame        (badf),
    .status_good_frame       (goodf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int good_n = 0;
  int ovf_n = 0;
  int bad_n = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor and event-pulse counters.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (rst_n) begin
      good_n += int'(goodf);
      ovf_n  += int'(ovf);
      bad_n  += int'(badf);
      if (m_axis_tvalid && m_axis_tready) begin
        total++;
        a = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: got %h want none", a);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL sb_beat: got %h want %h", a, e);
          end
        end
      end
    end
  end

  task automatic beat(input logic [DW-1:0] d,
                      input logic l, input logic u);
    s_axis_tdata  = d;
    s_axis_tkeep  = d[7:0];
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic frame(input int id, input int n,
                       input logic ulast, input bit push);
    logic [DW-1:0] d;
    logic l, u;
    for (int i = 0; i < n; i++) begin
      d = {32'(id), 32'(i)};
      l = (i == n - 1);
      u = l ? ulast : 1'b0;
      if (push) q.push_back('{d, d[7:0], l, u});
      beat(d, l, u);
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, o0, b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 32'(s_axis_tready), 0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_fcnt", 32'(fcnt), 0);
    chk("rst_ae", 32'(ae), 1);
    chk("rst_af", 32'(af), 0);
    chk("rst_pulses", 32'({ovf, badf, goodf}), 0);
    rst_n = 1'b1;
    idle(1);
    chk("run_tready", 32'(s_axis_tready), 1);

    // 3- then 5-beat frames, sink always ready
    g0 = good_n;
    frame(1, 3, 1'b0, 1'b1);
    chk("lat_t1", 32'(m_axis_tvalid), 0);
    chk("lat_fcnt", 32'(fcnt), 1);
    idle(1);
    chk("lat_t2", 32'(m_axis_tvalid), 1);
    frame(2, 5, 1'b0, 1'b1);
    idle(12);
    chk("a_fcnt", 32'(fcnt), 0);
    chk("a_good", 32'(good_n - g0), 2);
    chk("a_sbempty", 32'(q.size()), 0);

    // exactly DEPTH kept, DEPTH+1 dropped
    m_axis_tready = 1'b0;
    o0 = ovf_n;
    frame(20, 16, 1'b0, 1'b1);
    chk("ovs_occ16", 32'(occ), 16);
    chk("ovs_fcnt1", 32'(fcnt), 1);
    frame(21, 17, 1'b0, 1'b0);
    idle(2);
    chk("ovs_ovf", 32'(ovf_n - o0), 1);
    chk("ovs_fcnt", 32'(fcnt), 1);
    chk("ovs_occ15", 32'(occ), 15);
    chk("stall_valid", 32'(m_axis_tvalid), 1);
    chk("stall_id", m_axis_tdata[63:32], 20);
    chk("stall_idx", m_axis_tdata[31:0], 0);
    m_axis_tready = 1'b1;
    idle(22);
    chk("ovs_sbempty", 32'(q.size()), 0);
    chk("ovs_fcnt0", 32'(fcnt), 0);
    chk("ovs_occ0", 32'(occ), 0);

    // thresholds 12/2
    m_axis_tready = 1'b0;
    frame(30, 12, 1'b0, 1'b1);
    chk("th_af", 32'(af), 1);
    chk("th_ae", 32'(ae), 0);
    idle(1);
    m_axis_tready = 1'b1;
    idle(8);
    chk("th_occ3", 32'(occ), 3);
    chk("th_ae3", 32'(ae), 0);
    chk("th_af3", 32'(af), 0);
    idle(1);
    chk("th_ae2", 32'(ae), 1);
    idle(1);
    chk("th_ae1", 32'(ae), 1);
    idle(6);
    chk("th_sbempty", 32'(q.size()), 0);

    // commit and output tlast in the same cycle
    frame(50, 1, 1'b0, 1'b1);
    chk("sim_fcnt_a", 32'(fcnt), 1);
    idle(1);
    chk("sim_valid", 32'(m_axis_tvalid & m_axis_tlast), 1);
    frame(51, 1, 1'b0, 1'b1);
    chk("sim_fcnt_b", 32'(fcnt), 1);
    idle(4);
    chk("sim_fcnt_c", 32'(fcnt), 0);

    // flush with two frames buffered and a frame mid-input
    m_axis_tready = 1'b0;
    o0 = ovf_n;
    frame(10, 2, 1'b0, 1'b0);
    frame(11, 2, 1'b0, 1'b0);
    idle(3);
    chk("fl_pre_fcnt", 32'(fcnt), 2);
    beat({32'd12, 32'd0}, 1'b0, 1'b0);
    beat({32'd12, 32'd1}, 1'b0, 1'b0);
    flush = 1'b1;
    beat({32'd12, 32'd2}, 1'b0, 1'b0);
    flush = 1'b0;
    chk("fl_occ", 32'(occ), 0);
    chk("fl_fcnt", 32'(fcnt), 0);
    chk("fl_valid", 32'(m_axis_tvalid), 0);
    beat({32'd12, 32'd3}, 1'b0, 1'b0);
    beat({32'd12, 32'd4}, 1'b0, 1'b0);
    beat({32'd12, 32'd5}, 1'b1, 1'b0);
    idle(2);
    chk("fl_drop_occ", 32'(occ), 0);
    chk("fl_drop_fcnt", 32'(fcnt), 0);
    chk("fl_no_ovf", 32'(ovf_n - o0), 0);
    m_axis_tready = 1'b1;
    frame(13, 3, 1'b0, 1'b1);
    idle(6);
    chk("fl_sbempty", 32'(q.size()), 0);
    chk("fl_fcnt_end", 32'(fcnt), 0);

    // frame ending with tuser[0]=1
    g0 = good_n;
    b0 = bad_n;
    frame(40, 2, 1'b1, !DROP_BAD);
    idle(4);
    chk("bf_bad", 32'(bad_n - b0), 32'(DROP_BAD));
    chk("bf_good", 32'(good_n - g0), 32'(!DROP_BAD));
    frame(41, 2, 1'b0, 1'b1);
    idle(6);
    chk("bf_sbempty", 32'(q.size()), 0);
    chk("bf_fcnt", 32'(fcnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
